onchip_mem_port_arbiter: RTL and testbench



---
 rtl/onchip_mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_onchip_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_port_arbiter.sv
// Two-master sticky round-robin arbiter for the on-chip instrument memory s1 port.
// Define ARB_PERF_CNT_EN to add per-master grant/stall performance counters.
module onchip_mem_port_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int READ_LATENCY = 1,
  parameter int MAX_GRANT    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata
`ifdef ARB_PERF_CNT_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1,
  output logic [31:0]       stall_cnt0,
  output logic [31:0]       stall_cnt1
`endif
);

  localparam int CNT_W = $clog2(MAX_GRANT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_GRANT);

  logic             owner_reg, owner_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
  logic             req0, req1, pick1;
  logic             grant0, grant1, gnt_any, rd_accept;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  // Under contention the owner keeps the port until its run reaches MAX_GRANT.
  assign pick1 = (run_cnt_reg < MAX_CNT) ? owner_reg : ~owner_reg;

  // Grants are held off while reset is asserted so both masters see waitrequest.
  assign grant0  = reset_n & req0 & (~req1 | ~pick1);
  assign grant1  = reset_n & req1 & (~req0 | pick1);
  assign gnt_any = grant0 | grant1;

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  always_comb begin
    owner_next   = owner_reg;
    run_cnt_next = run_cnt_reg;
    if (gnt_any) begin
      if (grant1 == owner_reg) begin
        if (run_cnt_reg != MAX_CNT)
          run_cnt_next = run_cnt_reg + 1'b1;
      end else begin
        owner_next   = grant1;
        run_cnt_next = CNT_W'(1);
      end
    end else begin
      run_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_reg   <= 1'b0;
      run_cnt_reg <= '0;
    end else begin
      owner_reg   <= owner_next;
      run_cnt_reg <= run_cnt_next;
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    if (grant1) begin
      mem_address    = m1_address;
      mem_write      = m1_write;
      mem_writedata  = m1_writedata;
      mem_byteenable = m1_byteenable;
    end else if (grant0) begin
      mem_address    = m0_address;
      mem_write      = m0_write;
      mem_writedata  = m0_writedata;
      mem_byteenable = m0_byteenable;
    end
  end

  assign mem_chipselect = gnt_any;
  // A granted cycle without write is a read, since write wins when both are set.
  assign rd_accept      = gnt_any & ~mem_write;

  logic [READ_LATENCY-1:0] tag_valid_reg;
  logic [READ_LATENCY-1:0] tag_id_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
    end else begin
      tag_valid_reg[0] <= rd_accept;
      tag_id_reg[0]    <= grant1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_id_reg[i]    <= tag_id_reg[i-1];
      end
    end
  end

  assign m0_readdatavalid = tag_valid_reg[READ_LATENCY-1] & ~tag_id_reg[READ_LATENCY-1];
  assign m1_readdatavalid = tag_valid_reg[READ_LATENCY-1] &  tag_id_reg[READ_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

`ifdef ARB_PERF_CNT_EN
  logic [1:0]  acc_vec, stall_vec;
  logic [31:0] grant_cnt_reg [2];
  logic [31:0] stall_cnt_reg [2];

  assign acc_vec   = {grant1, grant0};
  assign stall_vec = {req1 & ~grant1, req0 & ~grant0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        grant_cnt_reg[gi] <= '0;
        stall_cnt_reg[gi] <= '0;
      end else if (perf_clr) begin
        grant_cnt_reg[gi] <= '0;
        stall_cnt_reg[gi] <= '0;
      end else begin
        if (acc_vec[gi] && grant_cnt_reg[gi] != 32'hFFFF_FFFF)
          grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 32'd1;
        if (stall_vec[gi] && stall_cnt_reg[gi] != 32'hFFFF_FFFF)
          stall_cnt_reg[gi] <= stall_cnt_reg[gi] + 32'd1;
      end
    end
  end

  assign grant_cnt0 = grant_cnt_reg[0];
  assign grant_cnt1 = grant_cnt_reg[1];
  assign stall_cnt0 = stall_cnt_reg[0];
  assign stall_cnt1 = stall_cnt_reg[1];
`endif

endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
// Bench for onchip_mem_port_arbiter: directed tables plus randomized traffic against a
// transaction-level model (owner/run bookkeeping, shadow memory, queue of due read responses).
module tb_onchip_mem_port_arbiter;
  localparam int AW = 19, DW = 32, BW = 4, RL = 2, MG = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
  logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          mem_chipselect, mem_write;

  always #5 clk = ~clk;

  onchip_mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .READ_LATENCY(RL), .MAX_GRANT(MG)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata)
  );

  // ---------------- memory environment (s1 with RL-cycle read latency) ----------------
  function automatic bit [31:0] init_word(int a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] nw, bit [3:0] be);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  bit   [31:0] mem [int];
  logic [31:0] rd_pipe [RL];

  function automatic bit [31:0] mem_rd(int a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_chipselect && mem_write)
      mem[int'(mem_address)] = merge(mem_rd(int'(mem_address)), mem_writedata, mem_byteenable);
    rd_pipe[0] <= mem_rd(int'(mem_address));
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_readdata = rd_pipe[RL-1];

  // ---------------- reference model ----------------
  typedef struct { int due; int id; bit [31:0] data; } rsp_t;
  typedef struct { bit r0; bit r1; bit ew0; bit ew1; } vec_t;

  bit [31:0] shadow [int];
  rsp_t      q[$];
  int        owner_m, run_m, cyc, last_g;
  bit        in_rst;
  bit        pend [2];
  int        nvec, nerr;
  vec_t      tbl [23];

  function automatic bit [31:0] sh_rd(int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_m(input int m, input bit r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (m == 0) begin
      m0_read = r; m0_write = w; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = r; m1_write = w; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic model_check();
    bit rq0, rq1, gw, e0, e1;
    int g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew, ed;
    logic [BW-1:0] eb;
    rsp_t r;
    rq0 = m0_read | m0_write;
    rq1 = m1_read | m1_write;
    g = -1;
    if (!in_rst) begin
      if (rq0 && !rq1)      g = 0;
      else if (rq1 && !rq0) g = 1;
      else if (rq0 && rq1)  g = (run_m < MG) ? owner_m : 1 - owner_m;
    end
    ea = '0; ew = '0; eb = '0; gw = 1'b0;
    if (g == 0) begin ea = m0_address; ew = m0_writedata; eb = m0_byteenable; gw = m0_write; end
    if (g == 1) begin ea = m1_address; ew = m1_writedata; eb = m1_byteenable; gw = m1_write; end
    chk("m0_waitrequest", m0_waitrequest, g != 0);
    chk("m1_waitrequest", m1_waitrequest, g != 1);
    chk("mem_chipselect", mem_chipselect, g >= 0);
    chk("mem_write", mem_write, gw);
    chk("mem_address", mem_address, ea);
    chk("mem_writedata", mem_writedata, ew);
    chk("mem_byteenable", mem_byteenable, eb);
    e0 = 1'b0; e1 = 1'b0; ed = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].id == 0) e0 = 1'b1; else e1 = 1'b1;
      ed = q[0].data;
      void'(q.pop_front());
    end
    chk("m0_readdatavalid", m0_readdatavalid, e0);
    chk("m1_readdatavalid", m1_readdatavalid, e1);
    if (e0) chk("m0_readdata", m0_readdata, ed);
    if (e1) chk("m1_readdata", m1_readdata, ed);
    if (g >= 0) begin
      if (gw) shadow[int'(ea)] = merge(sh_rd(int'(ea)), ew, eb);
      else begin
        r.due = cyc + RL; r.id = g; r.data = sh_rd(int'(ea));
        q.push_back(r);
      end
    end
    last_g = g;
  endtask

  task automatic model_update();
    if (in_rst) begin
      owner_m = 0; run_m = 0;
    end else if (last_g >= 0) begin
      if (last_g == owner_m) run_m = (run_m < MG) ? run_m + 1 : MG;
      else begin owner_m = last_g; run_m = 1; end
    end else begin
      run_m = 0;
    end
    cyc++;
  endtask

  // Called at posedge+1; checks at the falling edge, updates the model at the rising edge.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic enter_reset();
    reset_n = 1'b0; in_rst = 1'b1; q.delete(); owner_m = 0; run_m = 0;
  endtask

  task automatic leave_reset();
    reset_n = 1'b1; in_rst = 1'b0;
  endtask

  task automatic rand_drive();
    int k;
    for (int m = 0; m < 2; m++) begin
      if (!pend[m]) begin
        if ($urandom_range(99) < 60) begin
          k = int'($urandom_range(2));
          pend[m] = 1'b1;
          set_m(m, k != 1, k != 0, AW'($urandom_range(31)), DW'($urandom), BW'($urandom_range(15)));
        end else begin
          set_m(m, 1'b0, 1'b0, AW'($urandom), DW'($urandom), BW'($urandom));
        end
      end
    end
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0; last_g = -1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < 8; i++)   tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 8; i < 16; i++)  tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[22] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Reset held with m0 requesting a read
    set_m(0, 1'b1, 1'b0, AW'(5), '0, 4'hF);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    enter_reset();
    repeat (3) step();
    leave_reset();
    step();
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    repeat (RL - 1) step();
    chk("rst_rel_rdv0", m0_readdatavalid, 1'b1);
    chk("rst_rel_rdata", m0_readdata, init_word(5));

    // Single master write then read-back
    set_m(1, 1'b0, 1'b1, AW'('h10), 32'hDEAD_BEEF, 4'hF);
    #3 chk("sm_wr_wait1", m1_waitrequest, 1'b0);
    step();
    set_m(1, 1'b1, 1'b0, AW'('h10), '0, 4'hF);
    #3 chk("sm_rd_wait1", m1_waitrequest, 1'b0);
    step();
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (RL - 1) step();
    chk("sm_rdv1", m1_readdatavalid, 1'b1);
    chk("sm_rdata", m1_readdata, 32'hDEAD_BEEF);
    chk("sm_rdv0", m0_readdatavalid, 1'b0);
    repeat (2) step();

    // Contention blocks and owner-drop, from a fresh reset
    enter_reset();
    repeat (2) step();
    leave_reset();
    for (int i = 0; i < 23; i++) begin
      set_m(0, tbl[i].r0, 1'b0, AW'(5), '0, 4'hF);
      set_m(1, tbl[i].r1, 1'b0, AW'(6), '0, 4'hF);
      #3;
      chk("tbl_wait0", m0_waitrequest, tbl[i].ew0);
      chk("tbl_wait1", m1_waitrequest, tbl[i].ew1);
      step();
    end

    // Alternating reads m0 @5 / m1 @6
    for (int i = 0; i < 8; i++) begin
      set_m(0, (i % 2) == 0, 1'b0, AW'(5), '0, 4'hF);
      set_m(1, (i % 2) == 1, 1'b0, AW'(6), '0, 4'hF);
      #3;
      if (i >= RL) begin
        chk("alt_rdv0", m0_readdatavalid, ((i - RL) % 2) == 0);
        chk("alt_rdv1", m1_readdatavalid, ((i - RL) % 2) == 1);
        if (((i - RL) % 2) == 0) chk("alt_rdata0", m0_readdata, init_word(5));
        else                     chk("alt_rdata1", m1_readdata, init_word(6));
      end
      step();
    end
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (RL + 1) step();

    // Reset the cycle after an accepted read
    set_m(0, 1'b1, 1'b0, AW'(7), '0, 4'hF);
    step();
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    enter_reset();
    for (int i = 0; i < RL + 1; i++) begin
      #3;
      chk("mrr_rdv0", m0_readdatavalid, 1'b0);
      chk("mrr_wait0", m0_waitrequest, 1'b1);
      chk("mrr_wait1", m1_waitrequest, 1'b1);
      step();
    end
    leave_reset();
    repeat (RL + 1) begin
      #3 chk("mrr_post_rdv0", m0_readdatavalid, 1'b0);
      step();
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_drive();
      step();
      if (last_g >= 0) pend[last_g] = 1'b0;
    end
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (RL + 2) step();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
